// File: rtl/video_tpg_pkg.sv
// -----------------------------------------------------------------------------
// video_tpg_pkg
// Shared types and constants for the video test-pattern generator:
//   - state_t : frame sequencer states
//   - PAT_*   : pattern select codes carried on the 'pattern' input
// -----------------------------------------------------------------------------
package video_tpg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    localparam logic [1:0] PAT_RAMP_H  = 2'd0;
    localparam logic [1:0] PAT_RAMP_V  = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_SOLID   = 2'd3;

endpackage

// File: rtl/video_tpg_pattern.sv
// -----------------------------------------------------------------------------
// video_tpg_pattern
// Purely combinational pixel selector.
//   x, y     : low WIDTH bits of the pixel / line counters
//   pattern  : PAT_* select code
//   color    : value used by the solid pattern
//   pixel    : selected pixel value
// The checkerboard uses bit 3 of x and y (8x8 squares), so WIDTH must be >= 4.
// -----------------------------------------------------------------------------
module video_tpg_pattern
    import video_tpg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       pattern,
    input  logic [WIDTH-1:0] color,
    output logic [WIDTH-1:0] pixel
);

    always_comb begin
        pixel = '0;
        case (pattern)
            PAT_RAMP_H:  pixel = x;
            PAT_RAMP_V:  pixel = y;
            PAT_CHECKER: pixel = (x[3] ^ y[3]) ? '1 : '0;
            PAT_SOLID:   pixel = color;
            default:     pixel = '0;
        endcase
    end

endmodule

// File: rtl/video_tpg.sv
// -----------------------------------------------------------------------------
// video_tpg
// Video test-pattern generator producing a pixel stream with blanking.
//
// Ports:
//   clk          : single clock, all logic on posedge
//   rst          : synchronous reset, active low
//   en           : run request, sampled only at frame boundaries
//   pix_count    : active pixels per line (16 bits)
//   line_count   : active lines per frame (16 bits)
//   pattern      : 0 ramp-H, 1 ramp-V, 2 checkerboard, 3 solid
//   color        : solid-pattern value
//   dout         : pixel value, holds its last value while dv_out = 0
//   dv_out       : pixel valid (active region)
//   hs_out       : horizontal sync (HBLANK, and tail of each VBLANK line)
//   vs_out       : vertical sync (whole VBLANK region)
//   frame_cnt    : frame counter (only with VIDEO_TPG_FRAME_CNT_EN)
//   sof_out      : one-clock pulse with the first active pixel of a frame
//
// Configuration macro: VIDEO_TPG_FRAME_CNT_EN adds frame_cnt and turns the
// horizontal ramp into a moving ramp (x + frame number).
//
// All stream outputs are registered and reflect the sequencer state of the
// previous clock. pix_count, line_count and pattern are latched at each frame
// start so mid-frame changes only take effect on the next frame.
// WIDTH must lie in 4..16.
// -----------------------------------------------------------------------------
module video_tpg
    import video_tpg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HBLANK = 16,
    parameter int VBLANK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [15:0]      pix_count,
    input  logic [15:0]      line_count,
    input  logic [1:0]       pattern,
    input  logic [WIDTH-1:0] color,
    output logic [WIDTH-1:0] dout,
    output logic             dv_out,
    output logic             hs_out,
    output logic             vs_out,
`ifdef VIDEO_TPG_FRAME_CNT_EN
    output logic [15:0]      frame_cnt,
`endif
    output logic             sof_out
);

    localparam logic [15:0] HB_LAST = 16'(HBLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(VBLANK - 1);
    localparam logic [16:0] HB_LEN  = 17'(HBLANK);

    state_t      state, state_nxt;
    logic [15:0] x, y, x_nxt, y_nxt;
    logic [15:0] pix_l, lines_l;
    logic [1:0]  pat_l;
    logic        latch_cfg;
    logic        start_ok;
    logic        line_end;
    logic        sof_cond;
    logic [WIDTH-1:0] pixel;
    logic [WIDTH-1:0] pixel_sel;

    assign start_ok = en && (pix_count != 16'd0) && (line_count != 16'd0);
    // A VBLANK line is as long as an active line plus its horizontal blank;
    // 17 bits so a large pix_count plus HBLANK does not wrap.
    assign line_end = ({1'b0, x} == ({1'b0, pix_l} + HB_LEN - 17'd1));
    assign sof_cond = (state == ST_ACTIVE) && (x == 16'd0) && (y == 16'd0);

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        latch_cfg = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    latch_cfg = 1'b1;
                    x_nxt     = 16'd0;
                    y_nxt     = 16'd0;
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (x == pix_l - 16'd1) begin
                    x_nxt     = 16'd0;
                    state_nxt = ST_HBLANK;
                end else begin
                    x_nxt = x + 16'd1;
                end
            end
            ST_HBLANK: begin
                // x is reused as the blanking clock counter
                if (x == HB_LAST) begin
                    x_nxt = 16'd0;
                    if (y == lines_l - 16'd1) begin
                        y_nxt     = 16'd0;
                        state_nxt = ST_VBLANK;
                    end else begin
                        y_nxt     = y + 16'd1;
                        state_nxt = ST_ACTIVE;
                    end
                end else begin
                    x_nxt = x + 16'd1;
                end
            end
            ST_VBLANK: begin
                // x counts clocks within a blank line, y counts blank lines
                if (line_end) begin
                    x_nxt = 16'd0;
                    if (y == VB_LAST) begin
                        y_nxt = 16'd0;
                        if (start_ok) begin
                            latch_cfg = 1'b1;
                            state_nxt = ST_ACTIVE;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        y_nxt = y + 16'd1;
                    end
                end else begin
                    x_nxt = x + 16'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and latched frame configuration
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state   <= ST_IDLE;
            x       <= 16'd0;
            y       <= 16'd0;
            pix_l   <= 16'd0;
            lines_l <= 16'd0;
            pat_l   <= PAT_RAMP_H;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            if (latch_cfg) begin
                pix_l   <= pix_count;
                lines_l <= line_count;
                pat_l   <= pattern;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel selection
    // ------------------------------------------------------------------
    video_tpg_pattern #(
        .WIDTH(WIDTH)
    ) u_pattern (
        .x      (x[WIDTH-1:0]),
        .y      (y[WIDTH-1:0]),
        .pattern(pat_l),
        .color  (color),
        .pixel  (pixel)
    );

`ifdef VIDEO_TPG_FRAME_CNT_EN
    // frame_cnt steps on the same edge that registers the first pixel, so
    // that pixel still sees the old count; later pixels of the frame see the
    // incremented count and subtract one to keep the offset constant.
    always_comb begin
        pixel_sel = pixel;
        if (pat_l == PAT_RAMP_H) begin
            pixel_sel = x[WIDTH-1:0] + frame_cnt[WIDTH-1:0]
                        - (sof_cond ? WIDTH'(0) : WIDTH'(1));
        end
    end
`else
    assign pixel_sel = pixel;
`endif

    // ------------------------------------------------------------------
    // Registered stream outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout    <= '0;
            dv_out  <= 1'b0;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
            sof_out <= 1'b0;
`ifdef VIDEO_TPG_FRAME_CNT_EN
            frame_cnt <= 16'd0;
`endif
        end else begin
            dv_out  <= (state == ST_ACTIVE);
            hs_out  <= (state == ST_HBLANK) ||
                       ((state == ST_VBLANK) && (x >= pix_l));
            vs_out  <= (state == ST_VBLANK);
            sof_out <= sof_cond;
            if (state == ST_ACTIVE) begin
                dout <= pixel_sel;
            end
`ifdef VIDEO_TPG_FRAME_CNT_EN
            if (sof_cond) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
`endif
        end
    end

endmodule
